// File: rtl/conv_out_writer.sv
// conv_out_writer: capture/ack handshake storing conv pixels in a feature-map buffer.
// Build option CONV_WR_CHAN_ACC_EN: accumulate (saturating) across input channels.
module conv_out_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            npix,
    input  logic [3:0]            chan,
    input  logic                  valid,
    input  logic                  done,
    input  logic [DATA_WIDTH-1:0] out_pixel,
    input  logic [7:0]            addr,
    output logic                  save_done,
    input  logic [7:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE,
        CAPT,
        WRITE,
        ACK,
        WAITLOW
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] px_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] wdata;
    logic [7:0]            addr_q;
    logic [7:0]            pix_cnt;
    logic [3:0]            chan_q;
    logic                  done_q;
    logic                  in_range;
    logic                  wr_en;
    logic                  unused_ok;

    assign in_range = (addr_q < npix) && (int'(addr_q) < DEPTH);
    assign wr_en    = (state == WRITE) && in_range;
    assign busy     = (state != IDLE);

`ifdef CONV_WR_CHAN_ACC_EN
    logic [DATA_WIDTH:0] sum;

    // One guard bit: overflow when the two top bits of the sum disagree.
    always_comb begin
        sum   = {old_q[DATA_WIDTH-1], old_q} + {px_q[DATA_WIDTH-1], px_q};
        wdata = sum[DATA_WIDTH-1:0];
        if (chan_q == 4'd0) begin
            wdata = px_q;
        end else if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
            wdata = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    assign unused_ok = ^pix_cnt;
`else
    assign wdata     = px_q;
    assign unused_ok = ^{pix_cnt, chan_q, old_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            px_q       <= '0;
            addr_q     <= '0;
            chan_q     <= '0;
            done_q     <= 1'b0;
            old_q      <= '0;
            pix_cnt    <= '0;
            save_done  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            save_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pix_cnt    <= '0;
                        frame_done <= 1'b0;
                        err        <= 1'b0;
                    end
                    if (valid || done) begin
                        px_q   <= out_pixel;
                        addr_q <= addr;
                        chan_q <= chan;
                        done_q <= done;
                        state  <= CAPT;
                    end
                end
                CAPT: begin
                    old_q <= mem[addr_q];
                    state <= WRITE;
                end
                WRITE: begin
                    if (in_range) begin
                        pix_cnt <= pix_cnt + 8'd1;
                    end else begin
                        err <= 1'b1;
                    end
                    // The final pixel is acknowledged by frame_done alone.
                    if (done_q) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        save_done <= 1'b1;
                        state     <= ACK;
                    end
                end
                ACK: begin
                    state <= WAITLOW;
                end
                WAITLOW: begin
                    if (!valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_conv_out_writer.sv
// Randomized bench for conv_out_writer against an array-based buffer model.
// Honours CONV_WR_CHAN_ACC_EN the same way the design does.
module tb_conv_out_writer;

    localparam int W = 8;
`ifdef CONV_WR_CHAN_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         valid = 1'b0;
    logic         done = 1'b0;
    logic [7:0]   npix = 8'd0;
    logic [7:0]   addr = 8'd0;
    logic [7:0]   rd_addr = 8'd0;
    logic [3:0]   chan = 4'd0;
    logic [W-1:0] out_pixel = '0;
    logic         save_done;
    logic         busy;
    logic         frame_done;
    logic         err;
    logic [W-1:0] rd_data;

    int n_chk = 0;
    int n_pass = 0;
    int acks = 0;
    int ref_mem [256];
    bit known [256];
    bit ref_fd = 1'b0;
    bit ref_err = 1'b0;
    int ref_npix = 0;

    always #5 clk = ~clk;

    conv_out_writer #(.DATA_WIDTH(W), .DEPTH(256)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .npix       (npix),
        .chan       (chan),
        .valid      (valid),
        .done       (done),
        .out_pixel  (out_pixel),
        .addr       (addr),
        .save_done  (save_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag,
                      $signed(got), $signed(exp));
    endtask

    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_write(input int a, input int px, input int ch);
        if (a < ref_npix) begin
            if (ACC && ch != 0) ref_mem[a] = sat(ref_mem[a] + px);
            else ref_mem[a] = px;
            known[a] = 1'b1;
        end else begin
            ref_err = 1'b1;
        end
    endtask

    task automatic do_start(input int n);
        logic [31:0] nv;
        nv = n;
        npix = nv[7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ref_npix = n;
        ref_fd = 1'b0;
        ref_err = 1'b0;
        @(negedge clk);
        check("start_fd", 32'(frame_done), 32'(ref_fd));
        check("start_err", 32'(err), 32'(ref_err));
    endtask

    task automatic rd(input int a);
        logic [31:0] av;
        av = a;
        rd_addr = av[7:0];
        @(negedge clk);
        check("rd_data", {{24{rd_data[7]}}, rd_data}, ref_mem[a]);
    endtask

    task automatic send(input int px, input int a, input int ch,
                        input bit last, input int hold);
        logic [31:0] pv;
        logic [31:0] av;
        logic [31:0] cv;
        pv = px;
        av = a;
        cv = ch;
        out_pixel = pv[7:0];
        addr = av[7:0];
        chan = cv[3:0];
        done = last;
        valid = last ? 1'($urandom_range(0, 1)) : 1'b1;
        if (last) begin
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                check("done_noack", 32'(save_done), 32'd0);
                if (c == 2) begin
                    valid = 1'b0;
                    done = 1'b0;
                end
            end
            model_write(a, px, ch);
            ref_fd = 1'b1;
        end else begin
            for (int c = 1; c <= 5 + hold; c++) begin
                @(negedge clk);
                check("ack", 32'(save_done), 32'(c == 3));
                if (save_done) acks++;
                if (c == 3 + hold) valid = 1'b0;
            end
            model_write(a, px, ch);
        end
        check("busy_idle", 32'(busy), 32'd0);
        check("frame_done", 32'(frame_done), 32'(ref_fd));
        check("err", 32'(err), 32'(ref_err));
    endtask

    initial begin
        int a;
        int ch;
        int px;
        int seen;
        bit last;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_save_done", 32'(save_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pixel with valid held well past the ack.
        do_start(182);
        acks = 0;
        send(25, 0, 0, 1'b0, 3);
        rd(0);

        // Full frame: 181 acked pixels then the done pixel.
        for (int i = 1; i <= 180; i++)
            send(int'($urandom_range(0, 255)) - 128, i, 0, 1'b0,
                 int'($urandom_range(0, 2)));
        check("ack_count", acks, 32'd181);
        send(-7, 181, 0, 1'b1, 0);
        check("frame_ack_count", acks, 32'd181);
        rd(181);
        rd(0);
        rd(90);

        // Out-of-range addresses.
        send(33, 200, 0, 1'b0, 1);
        check("oor_ack", acks, 32'd182);
        do_start(100);
        send(55, 150, 0, 1'b0, 0);
        rd(150);
        do_start(182);

        // Randomized traffic.
        do_start(int'($urandom_range(120, 255)));
        for (int i = 0; i < 150; i++) begin
            a = int'($urandom_range(0, 255));
            ch = int'($urandom_range(0, 15));
            if (ACC && !known[a]) ch = 0;
            px = int'($urandom_range(0, 255)) - 128;
            last = ($urandom_range(0, 19) == 0);
            send(px, a, ch, last, int'($urandom_range(0, 3)));
            if (known[a]) rd(a);
            if (last) do_start(int'($urandom_range(120, 255)));
        end

        // Channel accumulation saturation corners.
        do_start(182);
        send(100, 5, 0, 1'b0, 0);
        send(60, 5, 1, 1'b0, 0);
        rd(5);
        send(-100, 6, 0, 1'b0, 1);
        send(-60, 6, 1, 1'b0, 1);
        rd(6);

        // Reset asserted while the ack is on the wire.
        out_pixel = 8'd77;
        addr = 8'd10;
        chan = 4'd0;
        valid = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (save_done) seen = 1;
        end
        check("ack_seen", seen, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ack_drop", 32'(save_done), 32'd0);
        check("rst_busy_drop", 32'(busy), 32'd0);
        check("rst_fd_clr", 32'(frame_done), 32'd0);
        model_write(10, 77, 0);
        ref_fd = 1'b0;
        ref_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (save_done) seen++;
        end
        check("post_rst_acks", seen, 32'd1);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        rd(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_out_writer.md
CONV_OUT_WRITER -- requirements
Module: conv_out_writer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the pixel width in bits (two's complement).
REQ-002 The block SHALL have parameter DEPTH, default 256, the number of feature-map buffer words, addressed by an 8-bit address.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that arms a new frame.
REQ-006 npix  input  8  the expected pixel count for the frame (out_h*out_w).
REQ-007 chan  input  4  the input-channel index of the current conv pass.
REQ-008 valid  input  1  the conv pixel-valid level; it is held until save_done is seen.
REQ-009 done  input  1  the conv final-pixel flag; it carries the last pixel of the frame.
REQ-010 out_pixel  input  DATA_WIDTH  the signed conv result.
REQ-011 addr  input  8  the raster address of out_pixel (row*out_w+col).
REQ-012 save_done  output  1  one-cycle acknowledge telling conv that the pixel is stored.
REQ-013 rd_addr  input  8  the read address used by the next layer.
REQ-014 rd_data  output  DATA_WIDTH  the buffer word at rd_addr, registered, 1-cycle latency.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 frame_done  output  1  sticky; set when the done pixel has been stored.
REQ-017 err  output  1  sticky; set on an out-of-range address.

Function
REQ-018 The FSM SHALL have the states IDLE, CAPT, WRITE, ACK and WAITLOW.
REQ-019 IDLE, with valid or done sampled high: the block SHALL register out_pixel, addr, chan and the done flag, then go to CAPT.
REQ-020 CAPT SHALL read mem[addr] (the old value) and go to WRITE.
REQ-021 WRITE SHALL write the new value to mem[addr] and increment pix_cnt (8-bit).
- If the captured flag is done, the block SHALL set frame_done and go to IDLE.
- Otherwise it SHALL go to ACK.
REQ-022 ACK SHALL drive save_done=1 for exactly one cycle, then go to WAITLOW.
- save_done is therefore high in the 3rd cycle after the edge that sampled valid.
REQ-023 WAITLOW SHALL return to IDLE only when valid=0, so one valid level is never stored twice.
REQ-024 No save_done SHALL be issued for the done pixel.
REQ-025 When valid and done are high together, the pixel SHALL be treated as the done pixel.
REQ-026 Range check: if captured addr >= npix, the write and the pix_cnt increment SHALL be suppressed and err set; the ack or frame_done sequence SHALL proceed unchanged.
REQ-027 start in IDLE SHALL clear pix_cnt, frame_done and err; start in any other state SHALL be ignored.
REQ-028 rd_data SHALL be mem[rd_addr] registered every cycle.
- A read in the same cycle as a write to the same address SHALL return the old value.

Reset
REQ-029 On rst_n=0 the FSM SHALL go to IDLE immediately and asynchronously, including mid-handshake.
REQ-030 During reset, save_done, busy, frame_done, err, rd_data and pix_cnt SHALL all be 0; buffer contents are not reset.
REQ-031 A transaction interrupted by reset SHALL be dropped with no ack.
- After release, a still-high valid SHALL be captured afresh.

Configuration
REQ-032 When CONV_WR_CHAN_ACC_EN is defined and the captured chan != 0, WRITE SHALL store sat(old + out_pixel).
- sat() is a DATA_WIDTH-bit signed add clamped to [-128, 127].
- When chan == 0, WRITE SHALL store out_pixel.
REQ-033 When CONV_WR_CHAN_ACC_EN is undefined, WRITE SHALL always store out_pixel.
- The CAPT read is still performed, so latency is identical in both builds.

Verification
REQ-034 Reset, start, npix=182; valid with pixel=25, addr=0, then hold valid -> save_done is a single pulse at cycle 3, mem[0]=25, and no second ack while valid stays high.
REQ-035 Valid for addr=0..180 followed by done with addr=181 and pixel=-7 -> 181 acks, frame_done=1, no ack for addr 181, and rd_addr=181 reads back -7 one cycle later.
REQ-036 Valid with addr=200 and npix=182 -> err=1, buffer unchanged, save_done still pulses; a following start clears err.
REQ-037 With CONV_WR_CHAN_ACC_EN: chan=0 pixel=100, then chan=1 pixel=60 on the same addr -> 127 (saturated).
- chan=1 pixel=-60 on an addr holding -100 -> -128.
- Without the macro -> the last pixel is stored.
REQ-038 rst_n pulsed low while in ACK -> save_done drops immediately and busy=0; with valid held high after release, capture restarts and exactly one ack is issued.
